// File: rtl/calc_pkg.sv
// Shared encodings for the subtract/divide unit: FSM states and operation selects.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage : calc_pkg

// File: rtl/nbit_subtractor.sv
// Ripple-borrow subtractor: diff_o = minuend_i - subtrahend_i, borrow_o set when the
// unsigned minuend is smaller than the subtrahend.
module nbit_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH:0] bw_chain;

  assign bw_chain[0] = 1'b0;

  // One full-subtractor cell per bit, borrow rippling from LSB to MSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    assign diff_o[gi]       = minuend_i[gi] ^ subtrahend_i[gi] ^ bw_chain[gi];
    assign bw_chain[gi + 1] = (~minuend_i[gi] & subtrahend_i[gi]) |
                              (~(minuend_i[gi] ^ subtrahend_i[gi]) & bw_chain[gi]);
  end

  assign borrow_o = bw_chain[WIDTH];

endmodule : nbit_subtractor

// File: rtl/seq_sub_divider.sv
// Subtract/divide unit for the calculator datapath. Subtract finishes in the accept
// cycle; divide is restoring, one quotient bit per CALC cycle. A single WIDTH+1-bit
// subtractor is shared between the subtract operation and the divide trial subtraction.
// Optional build macro DIVIDER_SIGNED_EN: two's complement operands (signed overflow on
// subtract, truncating signed divide with the sign fix applied when entering DONE).
module seq_sub_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             borrow,
  output logic             div_by_zero
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // latched divisor (magnitude)
  logic [WIDTH-1:0] prem_q, prem_d;    // partial remainder, always below the divisor
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             borrow_q, borrow_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sub_op_x, sub_op_y;
  logic [WIDTH:0]   sub_x, sub_y, sub_diff, shift_rem;
  logic             sub_borrow, sub_flag;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next, rem_next;
  logic [WIDTH-1:0] result_fin, rem_fin;
  logic             borrow_fin;

`ifdef DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic qneg_q, qneg_d;   // quotient must be negated
  logic rneg_q, rneg_d;   // remainder takes the dividend's sign
  logic ovf_q, ovf_d;     // MIN / -1

  // Divide runs on magnitudes; MIN maps onto 2^(WIDTH-1), which fits unsigned.
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;
  // Sign-extended subtract: top two result bits disagree exactly on signed overflow.
  assign sub_op_x = {a[WIDTH-1], a};
  assign sub_op_y = {b[WIDTH-1], b};
  assign sub_flag = sub_diff[WIDTH] ^ sub_diff[WIDTH-1];
  assign result_fin = qneg_q ? (~quo_next + 1'b1) : quo_next;
  assign rem_fin    = rneg_q ? (~rem_next + 1'b1) : rem_next;
  assign borrow_fin = ovf_q;
`else
  assign a_mag = a;
  assign b_mag = b;
  // Zero-extended subtract: the extra top bit is the unsigned borrow.
  assign sub_op_x = {1'b0, a};
  assign sub_op_y = {1'b0, b};
  assign sub_flag = sub_diff[WIDTH];
  assign result_fin = quo_next;
  assign rem_fin    = rem_next;
  assign borrow_fin = 1'b0;
`endif

  // Partial remainder shifted left with the next dividend MSB brought in.
  assign shift_rem = {prem_q, dvd_q[WIDTH-1]};

  // Share the subtractor: trial subtraction while dividing, operand subtract otherwise.
  always_comb begin
    sub_x = sub_op_x;
    sub_y = sub_op_y;
    if (state_q == ST_CALC) begin
      sub_x = shift_rem;
      sub_y = {1'b0, dvs_q};
    end
  end

  nbit_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .minuend_i   (sub_x),
    .subtrahend_i(sub_y),
    .diff_o      (sub_diff),
    .borrow_o    (sub_borrow)
  );

  // Restoring step: keep the difference when non-negative, otherwise restore.
  assign q_bit    = ~sub_borrow;
  assign rem_next = q_bit ? sub_diff[WIDTH-1:0] : shift_rem[WIDTH-1:0];
  assign quo_next = {dvd_q[WIDTH-2:0], q_bit};

  // Next-state and output-register update; outputs change only on entry to DONE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    borrow_d    = borrow_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    ovf_d  = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (op_sel == OP_SUB) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            result_d    = sub_diff[WIDTH-1:0];
            remainder_d = '0;
            borrow_d    = sub_flag;
            dbz_d       = 1'b0;
          end else if (b == '0) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            result_d    = '1;
            remainder_d = a;
            borrow_d    = 1'b0;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_CALC;
            count_d = '0;
            prem_d  = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
`ifdef DIVIDER_SIGNED_EN
            qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
            rneg_d = a[WIDTH-1];
            ovf_d  = (a == MIN_VAL) && (b == '1);
`endif
          end
        end
      end
      ST_CALC: begin
        count_d = count_q + 1'b1;
        dvd_d   = quo_next;
        prem_d  = rem_next;
        if (count_q == LAST_CNT) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          result_d    = result_fin;
          remainder_d = rem_fin;
          borrow_d    = borrow_fin;
          dbz_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset also aborts a divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      borrow_q    <= 1'b0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      borrow_q    <= borrow_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign ready       = (state_q != ST_CALC);
  assign done        = done_q;
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign borrow      = borrow_q;
  assign div_by_zero = dbz_q;

endmodule : seq_sub_divider

// File: tb/tb_seq_sub_divider.sv
// Self-checking bench for seq_sub_divider (WIDTH=4) against an arithmetic reference model.
module tb_seq_sub_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, borrow, div_by_zero;
  logic [W-1:0] result, remainder;

  int errs = 0;
  int checks = 0;

  seq_sub_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_sel     (op_sel),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .done       (done),
    .result     (result),
    .remainder  (remainder),
    .borrow     (borrow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_model(input logic op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                    output logic [W-1:0] r, output logic [W-1:0] m,
                                    output logic bw, output logic dz);
    int ia, ib, d;
`ifdef DIVIDER_SIGNED_EN
    ia = int'($signed(aa));
    ib = int'($signed(bb));
`else
    ia = int'(aa);
    ib = int'(bb);
`endif
    r = '0; m = '0; bw = 1'b0; dz = 1'b0;
    if (op == 1'b0) begin
      d = ia - ib;
      r = d[W-1:0];
`ifdef DIVIDER_SIGNED_EN
      bw = (d < -(2 ** (W - 1))) || (d > (2 ** (W - 1)) - 1);
`else
      bw = (d < 0);
`endif
    end else if (ib == 0) begin
      r = '1; m = aa; dz = 1'b1;
`ifdef DIVIDER_SIGNED_EN
    end else if (ia == -(2 ** (W - 1)) && ib == -1) begin
      r = aa; m = '0; bw = 1'b1;
`endif
    end else begin
      d = ia / ib;
      r = d[W-1:0];
      d = ia % ib;
      m = d[W-1:0];
    end
  endfunction

  // Issue one request at a negedge, scramble inputs after accept, wait (bounded) for done.
  task automatic run_op(input logic op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output int lat, output logic hold_ok, output logic busy_ok);
    logic [2*W+1:0] snap;
    start = 1'b1; op_sel = op; a = aa; b = bb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_sel = 1'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1; hold_ok = 1'b1; busy_ok = 1'b1;
    snap = {result, remainder, borrow, div_by_zero};
    while (done !== 1'b1 && lat < 40) begin
      if (ready !== 1'b0) busy_ok = 1'b0;
      if ({result, remainder, borrow, div_by_zero} !== snap) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    $display("txn op=%0d a=%0d b=%0d lat=%0d result=%0d remainder=%0d borrow=%0d dbz=%0d",
             op, aa, bb, lat, result, remainder, borrow, div_by_zero);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== '0) begin errs++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (remainder !== '0) begin errs++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    checks++; if (borrow !== 1'b0) begin errs++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
    checks++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat;
    logic hold_ok, busy_ok, ebw, edz;
    logic [W-1:0] ea, eb, er, em;
    run_op(1'b0, 4'd5, 4'd9, lat, hold_ok, busy_ok);
    checks++; if (lat != 1) begin errs++; $display("FAIL sub_latency got=%0d exp=1", lat); end
    checks++; if (result !== 4'b1100) begin errs++; $display("FAIL sub_result got=%b exp=1100", result); end
    checks++; if (borrow !== 1'b1) begin errs++; $display("FAIL sub_borrow got=%b exp=1", borrow); end
    checks++; if (remainder !== '0) begin errs++; $display("FAIL sub_remainder got=%h exp=0", remainder); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL sub_done_pulse got=%b exp=0", done); end
    for (int i = 0; i < 12; i++) begin
      ea = W'($urandom); eb = W'($urandom);
      ref_model(1'b0, ea, eb, er, em, ebw, edz);
      run_op(1'b0, ea, eb, lat, hold_ok, busy_ok);
      checks++;
      if (lat != 1 || result !== er || remainder !== em || borrow !== ebw || div_by_zero !== edz) begin
        errs++;
        $display("FAIL sub_rand a=%0d b=%0d got lat=%0d res=%h rem=%h bw=%b dz=%b exp lat=1 res=%h rem=%h bw=%b dz=%b",
                 ea, eb, lat, result, remainder, borrow, div_by_zero, er, em, ebw, edz);
      end
    end
  endtask

  task automatic test_div();
    int lat;
    logic hold_ok, busy_ok, ebw, edz;
    logic [W-1:0] ea, eb, er, em;
    run_op(1'b1, 4'd13, 4'd4, lat, hold_ok, busy_ok);
    checks++; if (lat != W + 1) begin errs++; $display("FAIL div_latency got=%0d exp=%0d", lat, W + 1); end
    checks++; if (result !== 4'd3) begin errs++; $display("FAIL div_result got=%0d exp=3", result); end
    checks++; if (remainder !== 4'd1) begin errs++; $display("FAIL div_remainder got=%0d exp=1", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errs++; $display("FAIL div_dbz got=%b exp=0", div_by_zero); end
    checks++; if (busy_ok !== 1'b1) begin errs++; $display("FAIL div_ready_busy got=%b exp=1", busy_ok); end
    checks++; if (hold_ok !== 1'b1) begin errs++; $display("FAIL div_outputs_hold got=%b exp=1", hold_ok); end
    for (int i = 0; i < 16; i++) begin
      ea = W'($urandom); eb = W'($urandom_range(1, 2 ** W - 1));
      ref_model(1'b1, ea, eb, er, em, ebw, edz);
      run_op(1'b1, ea, eb, lat, hold_ok, busy_ok);
      checks++;
      if (lat != W + 1 || result !== er || remainder !== em || borrow !== ebw || div_by_zero !== edz ||
          hold_ok !== 1'b1 || busy_ok !== 1'b1) begin
        errs++;
        $display("FAIL div_rand a=%0d b=%0d got lat=%0d res=%h rem=%h bw=%b dz=%b hold=%b busy=%b exp lat=%0d res=%h rem=%h bw=%b dz=%b",
                 ea, eb, lat, result, remainder, borrow, div_by_zero, hold_ok, busy_ok, W + 1, er, em, ebw, edz);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic hold_ok, busy_ok;
    logic [W-1:0] ea;
    run_op(1'b1, 4'd7, 4'd0, lat, hold_ok, busy_ok);
    checks++; if (lat != 1) begin errs++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++; if (result !== 4'hF) begin errs++; $display("FAIL dbz_result got=%h exp=f", result); end
    checks++; if (remainder !== 4'd7) begin errs++; $display("FAIL dbz_remainder got=%0d exp=7", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errs++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    checks++; if (borrow !== 1'b0) begin errs++; $display("FAIL dbz_borrow got=%b exp=0", borrow); end
    for (int i = 0; i < 4; i++) begin
      ea = W'($urandom);
      run_op(1'b1, ea, 4'd0, lat, hold_ok, busy_ok);
      checks++;
      if (lat != 1 || result !== 4'hF || remainder !== ea || div_by_zero !== 1'b1) begin
        errs++;
        $display("FAIL dbz_rand a=%0d got lat=%0d res=%h rem=%h dz=%b exp lat=1 res=f rem=%h dz=1",
                 ea, lat, result, remainder, div_by_zero, ea);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, extra;
    start = 1'b1; op_sel = 1'b1; a = 4'd15; b = 4'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lat = 1;
    @(negedge clk);
    lat++;
    start = 1'b1; op_sel = 1'b1; a = 4'd2; b = 4'd1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("txn op=1 a=15 b=1 (start during CALC) lat=%0d result=%0d remainder=%0d", lat, result, remainder);
    checks++; if (lat != W + 1) begin errs++; $display("FAIL busy_latency got=%0d exp=%0d", lat, W + 1); end
    checks++; if (result !== 4'd15) begin errs++; $display("FAIL busy_result got=%0d exp=15", result); end
    checks++; if (remainder !== 4'd0) begin errs++; $display("FAIL busy_remainder got=%0d exp=0", remainder); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errs++; $display("FAIL busy_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_rst_mid_calc();
    int seen;
    start = 1'b1; op_sel = 1'b1; a = 4'd9; b = 4'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("txn op=1 a=9 b=2 (rst mid-CALC) ready=%b done=%b result=%0d remainder=%0d", ready, done, result, remainder);
    checks++; if (ready !== 1'b1) begin errs++; $display("FAIL rstcalc_ready got=%b exp=1", ready); end
    checks++;
    if ({done, result, remainder, borrow, div_by_zero} !== '0) begin
      errs++;
      $display("FAIL rstcalc_outputs got done=%b res=%h rem=%h bw=%b dz=%b exp all 0",
               done, result, remainder, borrow, div_by_zero);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errs++; $display("FAIL rstcalc_no_done got=%0d exp=0", seen); end
  endtask

  task automatic test_rst_start_same_edge();
    int lat, seen;
    logic hold_ok, busy_ok;
    run_op(1'b0, 4'd3, 4'd1, lat, hold_ok, busy_ok);
    checks++; if (result !== 4'd2) begin errs++; $display("FAIL rststart_pre got=%0d exp=2", result); end
    rst = 1'b1; start = 1'b1; op_sel = 1'b0; a = 4'd5; b = 4'd9;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (4) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    $display("txn op=0 a=5 b=9 (rst same edge) result=%0d borrow=%b", result, borrow);
    checks++; if (seen != 0) begin errs++; $display("FAIL rststart_done got=%0d exp=0", seen); end
    checks++;
    if (result !== '0 || borrow !== 1'b0) begin
      errs++; $display("FAIL rststart_outputs got res=%h bw=%b exp res=0 bw=0", result, borrow);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start = 1'b1; op_sel = 1'b0; a = 4'd6; b = 4'd2;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== 4'd4 || ready !== 1'b1) begin
      errs++; $display("FAIL b2b_first got done=%b res=%0d ready=%b exp done=1 res=4 ready=1", done, result, ready);
    end
    op_sel = 1'b1; a = 4'd13; b = 4'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("txn op=1 a=13 b=4 (start held in DONE) lat=%0d result=%0d remainder=%0d", lat, result, remainder);
    checks++;
    if (lat != W + 1 || result !== 4'd3 || remainder !== 4'd1) begin
      errs++; $display("FAIL b2b_second got lat=%0d res=%0d rem=%0d exp lat=%0d res=3 rem=1", lat, result, remainder, W + 1);
    end
    @(negedge clk);
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    int lat;
    logic hold_ok, busy_ok;
    run_op(1'b1, 4'b1001, 4'd2, lat, hold_ok, busy_ok);
    checks++;
    if (result !== 4'b1101 || remainder !== 4'b1111) begin
      errs++; $display("FAIL signed_div got res=%b rem=%b exp res=1101 rem=1111", result, remainder);
    end
    run_op(1'b1, 4'b1000, 4'b1111, lat, hold_ok, busy_ok);
    checks++;
    if (result !== 4'b1000 || remainder !== 4'b0000 || borrow !== 1'b1 || lat != W + 1) begin
      errs++; $display("FAIL signed_minovf got res=%b rem=%b bw=%b lat=%0d exp res=1000 rem=0000 bw=1 lat=%0d",
                       result, remainder, borrow, lat, W + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sub();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_rst_mid_calc();
    test_rst_start_same_edge();
    test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_seq_sub_divider
